// File: rtl/i2s_sample_fifo.sv
// i2s_sample_fifo: bclk-domain sample buffer between the I2S receiver and the
// DSP/transmitter feed. First-word-fall-through read side, occupancy held in
// its own register, sticky overflow flag with a saturating event counter and
// a selectable drop policy (discard incoming or discard oldest).
module i2s_sample_fifo #(
    parameter int WORD_WIDTH  = 24,
    parameter int DEPTH_LOG2  = 4,
    parameter int DROP_OLDEST = 0
) (
    input  logic                  bclk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] in_sample,
    input  logic                  in_valid,
    output logic [WORD_WIDTH-1:0] out_sample,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  overflow,
    output logic [15:0]           overflow_count,
    input  logic                  overflow_clear
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   lvl_t;

    localparam lvl_t DEPTH_LVL = lvl_t'(DEPTH);
    localparam ptr_t PTR_ONE   = ptr_t'(1'b1);
    localparam lvl_t LVL_ONE   = lvl_t'(1'b1);

    logic [WORD_WIDTH-1:0] mem_r [DEPTH];
    ptr_t                  wr_ptr_r;
    ptr_t                  rd_ptr_r;
    lvl_t                  level_r;
    logic                  out_valid_r;
    logic                  full_r;
    logic                  overflow_r;
    logic [15:0]           overflow_count_r;

    logic        push_s;
    logic        pop_s;
    logic        at_full_s;
    logic        wr_en_s;
    logic        rd_adv_s;
    lvl_t        level_nxt_s;
    logic        ovf_evt_s;
    logic        overflow_nxt_s;
    logic [15:0] count_nxt_s;

    // Decide what happens to storage, pointers and occupancy this cycle.
    always_comb begin
        push_s      = in_valid & ~rst;
        pop_s       = out_valid_r & out_ready;
        at_full_s   = (level_r == DEPTH_LVL);
        wr_en_s     = 1'b0;
        rd_adv_s    = 1'b0;
        level_nxt_s = level_r;
        ovf_evt_s   = 1'b0;
        if (push_s && pop_s) begin
            // Simultaneous write and read, even when full: occupancy unchanged.
            wr_en_s  = 1'b1;
            rd_adv_s = 1'b1;
        end else if (push_s && !at_full_s) begin
            wr_en_s     = 1'b1;
            level_nxt_s = level_r + LVL_ONE;
        end else if (push_s) begin
            // Full with nobody reading: overflow, policy picks the victim.
            ovf_evt_s = 1'b1;
            if (DROP_OLDEST != 0) begin
                wr_en_s  = 1'b1;
                rd_adv_s = 1'b1;
            end else begin
                wr_en_s  = 1'b0;
                rd_adv_s = 1'b0;
            end
        end else if (pop_s) begin
            rd_adv_s    = 1'b1;
            level_nxt_s = level_r - LVL_ONE;
        end else begin
            level_nxt_s = level_r;
        end
    end

    // Overflow flag and saturating counter; an event beats a coincident clear.
    always_comb begin
        overflow_nxt_s = overflow_r;
        count_nxt_s    = overflow_count_r;
        if (ovf_evt_s) begin
            overflow_nxt_s = 1'b1;
            if (overflow_clear) begin
                count_nxt_s = 16'd1;
            end else if (overflow_count_r == 16'hFFFF) begin
                count_nxt_s = 16'hFFFF;
            end else begin
                count_nxt_s = overflow_count_r + 16'd1;
            end
        end else if (overflow_clear) begin
            overflow_nxt_s = 1'b0;
            count_nxt_s    = 16'd0;
        end else begin
            overflow_nxt_s = overflow_r;
            count_nxt_s    = overflow_count_r;
        end
    end

    // Control state: pointers, occupancy and the registered status outputs.
    always_ff @(posedge bclk) begin
        if (rst) begin
            wr_ptr_r         <= '0;
            rd_ptr_r         <= '0;
            level_r          <= '0;
            out_valid_r      <= 1'b0;
            full_r           <= 1'b0;
            overflow_r       <= 1'b0;
            overflow_count_r <= 16'd0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_adv_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r          <= level_nxt_s;
            out_valid_r      <= (level_nxt_s != '0);
            full_r           <= (level_nxt_s == DEPTH_LVL);
            overflow_r       <= overflow_nxt_s;
            overflow_count_r <= count_nxt_s;
        end
    end

    // Sample storage; contents deliberately survive reset.
    always_ff @(posedge bclk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= in_sample;
        end
    end

    assign out_sample     = out_valid_r ? mem_r[rd_ptr_r] : {WORD_WIDTH{1'b0}};
    assign out_valid      = out_valid_r;
    assign level          = level_r;
    assign full           = full_r;
    assign overflow       = overflow_r;
    assign overflow_count = overflow_count_r;

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// Self-checking bench for i2s_sample_fifo: two instances (discard-incoming and
// discard-oldest) driven in lockstep and compared every cycle against a
// queue-based reference model, plus directed vectors and corner sequences.
module tb_i2s_sample_fifo;

    localparam int W     = 24;
    localparam int DEPTH = 16;

    typedef logic [W-1:0] q_t[$];

    typedef struct {
        logic         iv;
        logic [W-1:0] s;
        logic         r;
        logic [4:0]   lvl;
        logic         vld;
        logic [W-1:0] os;
    } vec_t;

    logic         bclk;
    logic         rst;
    logic [W-1:0] in_sample;
    logic         in_valid;
    logic         out_ready;
    logic         overflow_clear;

    logic [W-1:0] os   [2];
    logic         ov_o [2];
    logic [4:0]   lv   [2];
    logic         fl   [2];
    logic         of   [2];
    logic [15:0]  oc   [2];

    int checks = 0;
    int errors = 0;

    q_t mq0;
    q_t mq1;
    bit mo [2];
    int mc [2];

    vec_t vt [9];

    i2s_sample_fifo #(.WORD_WIDTH(W), .DEPTH_LOG2(4), .DROP_OLDEST(0)) u_keep (
        .bclk(bclk), .rst(rst), .in_sample(in_sample), .in_valid(in_valid),
        .out_sample(os[0]), .out_valid(ov_o[0]), .out_ready(out_ready),
        .level(lv[0]), .full(fl[0]), .overflow(of[0]),
        .overflow_count(oc[0]), .overflow_clear(overflow_clear)
    );

    i2s_sample_fifo #(.WORD_WIDTH(W), .DEPTH_LOG2(4), .DROP_OLDEST(1)) u_drop (
        .bclk(bclk), .rst(rst), .in_sample(in_sample), .in_valid(in_valid),
        .out_sample(os[1]), .out_valid(ov_o[1]), .out_ready(out_ready),
        .level(lv[1]), .full(fl[1]), .overflow(of[1]),
        .overflow_count(oc[1]), .overflow_clear(overflow_clear)
    );

    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: a plain queue per policy; head is q[0].
    task automatic model_update(input int k, input logic iv, input logic [W-1:0] s,
                                input logic r, input logic clr, input logic rs);
        q_t q;
        bit ev;
        if (k == 0) q = mq0; else q = mq1;
        if (rs) begin
            q.delete();
            mo[k] = 1'b0;
            mc[k] = 0;
        end else begin
            ev = 1'b0;
            if (q.size() > 0 && r) void'(q.pop_front());
            if (iv) begin
                if (q.size() < DEPTH) begin
                    q.push_back(s);
                end else begin
                    ev = 1'b1;
                    if (k == 1) begin
                        void'(q.pop_front());
                        q.push_back(s);
                    end
                end
            end
            if (ev) begin
                mo[k] = 1'b1;
                mc[k] = clr ? 1 : ((mc[k] == 65535) ? 65535 : mc[k] + 1);
            end else if (clr) begin
                mo[k] = 1'b0;
                mc[k] = 0;
            end
        end
        if (k == 0) mq0 = q; else mq1 = q;
    endtask

    task automatic model_check(input int k);
        q_t           q;
        logic [W-1:0] hd;
        if (k == 0) q = mq0; else q = mq1;
        hd = (q.size() > 0) ? q[0] : 24'h000000;
        chk($sformatf("d%0d_level", k), 32'(lv[k]), 32'(q.size()));
        chk($sformatf("d%0d_out_valid", k), 32'(ov_o[k]), 32'(q.size() > 0));
        chk($sformatf("d%0d_out_sample", k), 32'(os[k]), 32'(hd));
        chk($sformatf("d%0d_full", k), 32'(fl[k]), 32'(q.size() == DEPTH));
        chk($sformatf("d%0d_overflow", k), 32'(of[k]), 32'(mo[k]));
        chk($sformatf("d%0d_ovf_count", k), 32'(oc[k]), 32'(mc[k]));
    endtask

    // One clock: drive inputs, let the edge pass, update model, compare.
    task automatic step(input logic iv, input logic [W-1:0] s, input logic r,
                        input logic clr, input logic rs);
        in_valid       = iv;
        in_sample      = s;
        out_ready      = r;
        overflow_clear = clr;
        rst            = rs;
        @(posedge bclk);
        #1;
        for (int k = 0; k < 2; k++) begin
            model_update(k, iv, s, r, clr, rs);
            model_check(k);
        end
    endtask

    initial begin
        vt[0] = '{1'b1, 24'h000001, 1'b0, 5'd1, 1'b1, 24'h000001};
        vt[1] = '{1'b1, 24'h000002, 1'b0, 5'd2, 1'b1, 24'h000001};
        vt[2] = '{1'b1, 24'h000003, 1'b0, 5'd3, 1'b1, 24'h000001};
        vt[3] = '{1'b0, 24'h000000, 1'b1, 5'd2, 1'b1, 24'h000002};
        vt[4] = '{1'b0, 24'h000000, 1'b1, 5'd1, 1'b1, 24'h000003};
        vt[5] = '{1'b0, 24'h000000, 1'b1, 5'd0, 1'b0, 24'h000000};
        vt[6] = '{1'b0, 24'h000000, 1'b1, 5'd0, 1'b0, 24'h000000};
        vt[7] = '{1'b1, 24'h800000, 1'b1, 5'd1, 1'b1, 24'h800000};
        vt[8] = '{1'b0, 24'h000000, 1'b1, 5'd0, 1'b0, 24'h000000};

        in_valid = 1'b0; in_sample = '0; out_ready = 1'b0;
        overflow_clear = 1'b0; rst = 1'b1;

        // Reset state
        step(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
        chk("rst_level", 32'(lv[0]), 32'd0);
        chk("rst_valid", 32'(ov_o[0]), 32'd0);
        chk("rst_sample", 32'(os[0]), 32'd0);

        // Directed vector table: basic FWFT order, underrun, empty push+ready
        for (int i = 0; i < 9; i++) begin
            step(vt[i].iv, vt[i].s, vt[i].r, 1'b0, 1'b0);
            chk($sformatf("vec%0d_level", i), 32'(lv[0]), 32'(vt[i].lvl));
            chk($sformatf("vec%0d_valid", i), 32'(ov_o[0]), 32'(vt[i].vld));
            chk($sformatf("vec%0d_sample", i), 32'(os[0]), 32'(vt[i].os));
        end

        // Overflow under both policies: 18 writes, no reads
        step(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 18; i++) step(1'b1, 24'(32'h100 + i), 1'b0, 1'b0, 1'b0);
        chk("ovf_keep_full", 32'(fl[0]), 32'd1);
        chk("ovf_keep_level", 32'(lv[0]), 32'd16);
        chk("ovf_keep_flag", 32'(of[0]), 32'd1);
        chk("ovf_keep_count", 32'(oc[0]), 32'd2);
        chk("ovf_drop_level", 32'(lv[1]), 32'd16);
        chk("ovf_drop_count", 32'(oc[1]), 32'd2);
        for (int i = 0; i < 16; i++) begin
            chk("drain_keep", 32'(os[0]), 32'h100 + i);
            chk("drain_drop", 32'(os[1]), 32'h102 + i);
            step(1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
        end
        chk("drained_level", 32'(lv[0]), 32'd0);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 16; i++) step(1'b1, 24'(32'h200 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 24'hABCDEF, 1'b1, 1'b0, 1'b0);
        chk("pp_keep_level", 32'(lv[0]), 32'd16);
        chk("pp_drop_level", 32'(lv[1]), 32'd16);
        chk("pp_keep_count", 32'(oc[0]), 32'd2);
        chk("pp_drop_count", 32'(oc[1]), 32'd2);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                chk("pp_last_keep", 32'(os[0]), 32'hABCDEF);
                chk("pp_last_drop", 32'(os[1]), 32'hABCDEF);
            end
            step(1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
        end

        // Continuous stream across pointer wrap
        step(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] s;
            s = (i == 20) ? 24'h800000 : 24'($urandom);
            step(1'b1, s, 1'b1, 1'b0, 1'b0);
            chk("stream_level", 32'(lv[0]), 32'd1);
            chk("stream_data", 32'(os[0]), 32'(s));
        end
        step(1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
        chk("stream_end_level", 32'(lv[0]), 32'd0);
        chk("stream_no_ovf", 32'(of[0]), 32'd0);

        // Overflow coincident with clear, then clear alone, then mid-stream reset
        step(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 24'(32'h300 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 24'h000777, 1'b0, 1'b1, 1'b0);
        chk("clr_evt_flag", 32'(of[0]), 32'd1);
        chk("clr_evt_count", 32'(oc[0]), 32'd1);
        chk("clr_evt_count_drop", 32'(oc[1]), 32'd1);
        step(1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
        chk("clr_flag", 32'(of[0]), 32'd0);
        chk("clr_count", 32'(oc[0]), 32'd0);
        step(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 24'(32'h400 + i), 1'b0, 1'b0, 1'b0);
        chk("pre_rst_level", 32'(lv[0]), 32'd7);
        step(1'b1, 24'h000999, 1'b0, 1'b0, 1'b1);
        chk("mid_rst_level", 32'(lv[0]), 32'd0);
        chk("mid_rst_valid", 32'(ov_o[0]), 32'd0);
        chk("mid_rst_sample", 32'(os[0]), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            logic iv, r, clr, rs;
            iv  = ($urandom_range(0, 99) < 60);
            r   = ($urandom_range(0, 99) < ((i / 250) % 2 == 0 ? 30 : 70));
            clr = ($urandom_range(0, 99) < 3);
            rs  = ($urandom_range(0, 999) < 5);
            step(iv, 24'($urandom), r, clr, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_sample_fifo.md
Name: i2s_sample_fifo

Overview:
- Single-clock sample buffer in the bclk domain, placed directly downstream of the mono I2S receiver.
- Accepts one-cycle sample/sample_valid pulses from the receiver.
- Presents them first-word-fall-through on a valid/ready interface to the DSP core or transmitter feed.
- Absorbs processing jitter, reports fill level, and counts overflows under a selectable drop policy.

Parameters:
- WORD_WIDTH, 24, sample width in bits (signed two's complement, passed through unmodified).
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (16 by default); legal range 1..8.
- DROP_OLDEST, 0, overflow policy: 0 = discard incoming sample, 1 = discard oldest stored sample and keep incoming.

Ports:
- bclk  in  1  bit clock; sole clock of the block, all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- in_sample  in  WORD_WIDTH  sample from receiver.
- in_valid  in  1  one-cycle write strobe; no back-pressure to the receiver.
- out_sample  out  WORD_WIDTH  head-of-FIFO sample; forced 0 when out_valid=0.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head when out_valid & out_ready.
- level  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- full  out  1  level == DEPTH.
- overflow  out  1  sticky flag, set on any overflow event.
- overflow_count  out  16  saturating count of overflow events.
- overflow_clear  in  1  clears overflow and overflow_count.

Behaviour:
- Reset (synchronous, when rst=1 at posedge bclk): all state is cleared and all outputs take these values on the next cycle.
  - wr_ptr=0, rd_ptr=0, level=0.
  - out_valid=0, out_sample=0, full=0.
  - overflow=0, overflow_count=0.
  - Memory contents are not cleared.
  - Reset asserted mid-stream discards all buffered samples; in_valid coincident with rst is ignored.
- Storage and pointers:
  - DEPTH-entry array with DEPTH_LOG2-bit wrapping pointers.
  - level is held as a separate register; full/empty are derived from level, not from pointer compare.
- Read side (FWFT):
  - out_sample = mem[rd_ptr] whenever level>0; out_valid = (level>0).
  - pop = out_valid & out_ready; on pop, rd_ptr increments (wrapping DEPTH-1 -> 0).
- Write latency: in_valid in cycle N into an empty FIFO -> out_valid=1 and out_sample=that sample in cycle N+1.
- Write side: push = in_valid & ~rst. Per cycle, given level L:
  - push, no pop, L<DEPTH: write at wr_ptr, wr_ptr++, level=L+1.
  - pop, no push, L>0: level=L-1.
  - push and pop, 0<L<=DEPTH: write and read both occur, level unchanged, not an overflow (including when full).
  - push, no pop, L==DEPTH, DROP_OLDEST=0: sample discarded, pointers and level unchanged, overflow event.
  - push, no pop, L==DEPTH, DROP_OLDEST=1: write at wr_ptr, wr_ptr++ and rd_ptr++, level stays DEPTH, overflow event. out_sample advances to the next-oldest sample the following cycle.
  - push with L==0 and out_ready=1: no pop this cycle (out_valid was 0); level=1.
  - out_ready with no push and L==0: no effect (underrun is not an error and is not counted).
- Overflow reporting:
  - Event: overflow<=1; overflow_count increments and saturates at 16'hFFFF.
  - overflow_clear alone: overflow<=0, overflow_count<=0.
  - overflow_clear coincident with an event: the event wins, giving overflow=1, overflow_count=1.
- Timing: all outputs except out_sample are registered; out_sample is a combinational read of the array at the registered rd_ptr, with no combinational path from inputs.
- Pointer wrap: pointers wrap modulo DEPTH; level is never derived from pointer difference.

Test Plan:
1. Reset, then write 0x000001, 0x000002, 0x000003 on consecutive cycles with out_ready=0.
   -> level 1,2,3; out_valid rises the cycle after the first write; out_sample=0x000001.
   -> Then raise out_ready for 3 cycles: reads 0x000001, 0x000002, 0x000003 in order, then out_valid=0, level=0, out_sample=0.
2. DEPTH_LOG2=4, DROP_OLDEST=0: write 0x100..0x111 (18 samples), no reads.
   -> full=1, level=16, overflow=1, overflow_count=2.
   -> Draining yields 0x100..0x10F.
3. Same stimulus with DROP_OLDEST=1.
   -> level=16, overflow_count=2.
   -> Draining yields 0x102..0x111.
4. Full FIFO with simultaneous push 0xABCDEF and pop.
   -> level stays 16, overflow count unchanged, 0xABCDEF appears last on drain.
5. Continuous 40-cycle stream with in_valid every cycle and out_ready every cycle (crossing pointer wrap twice).
   -> level toggles 0/1 only, output order equals input order, no overflow.
   -> Signed value 0x800000 passes unchanged.
6. Force an overflow event in the same cycle as overflow_clear -> overflow=1, count=1.
   - Then overflow_clear alone -> both 0.
   - Assert rst with level=7 -> next cycle level=0, out_valid=0, out_sample=0.
